// File: rtl/rv32i_decoder.sv
// RV32I decode/operand stage: decodes i_inst and registers ALU operands, selects and class flags.
// One-cycle latency; i_stall holds every registered output, i_flush (which overrides stall) kills the captured slot.
module rv32i_decoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_alu_add,
  output logic        o_alu_sub,
  output logic        o_alu_slt,
  output logic        o_alu_sltu,
  output logic        o_alu_xor,
  output logic        o_alu_or,
  output logic        o_alu_and,
  output logic        o_alu_sll,
  output logic        o_alu_srl,
  output logic        o_alu_sra,
  output logic        o_alu_eq,
  output logic        o_alu_neq,
  output logic        o_alu_ge,
  output logic        o_alu_geu,
  output logic        o_alu,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [31:0] o_rs2_data,
  output logic [2:0]  o_funct3,
  output logic        o_load,
  output logic        o_store,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_lui,
  output logic        o_auipc,
  output logic        o_system,
  output logic        o_fence,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic op_add;
    logic op_sub;
    logic op_slt;
    logic op_sltu;
    logic op_xor;
    logic op_or;
    logic op_and;
    logic op_sll;
    logic op_srl;
    logic op_sra;
    logic op_eq;
    logic op_neq;
    logic op_ge;
    logic op_geu;
  } alu_sel_t;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
    logic fence;
  } cls_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       f7_alt;

  assign opcode  = i_inst[6:0];
  assign funct3  = i_inst[14:12];
  assign funct7  = i_inst[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;

  assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u  = {i_inst[31:12], 12'b0};
  assign imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  // Shift-immediates carry only the shamt; funct7 bits are opcode, not operand.
  assign imm_sh = {27'b0, i_inst[24:20]};

  alu_sel_t    sel_d;
  alu_sel_t    sel_q;
  cls_t        cls_d;
  cls_t        cls_q;
  logic        ill_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic [31:0] imm_d;
  logic [4:0]  rd_d;

  always_comb begin
    sel_d = '0;
    cls_d = '0;
    ill_d = 1'b0;
    a_d   = '0;
    b_d   = '0;
    imm_d = '0;
    rd_d  = i_inst[11:7];

    case (opcode)
      OPC_OP: begin
        a_d = i_rs1_data;
        b_d = i_rs2_data;
        case (funct3)
          3'b000: begin
            if (f7_zero)     sel_d.op_add = 1'b1;
            else if (f7_alt) sel_d.op_sub = 1'b1;
            else             ill_d = 1'b1;
          end
          3'b001:  if (f7_zero) sel_d.op_sll  = 1'b1; else ill_d = 1'b1;
          3'b010:  if (f7_zero) sel_d.op_slt  = 1'b1; else ill_d = 1'b1;
          3'b011:  if (f7_zero) sel_d.op_sltu = 1'b1; else ill_d = 1'b1;
          3'b100:  if (f7_zero) sel_d.op_xor  = 1'b1; else ill_d = 1'b1;
          3'b110:  if (f7_zero) sel_d.op_or   = 1'b1; else ill_d = 1'b1;
          3'b111:  if (f7_zero) sel_d.op_and  = 1'b1; else ill_d = 1'b1;
          default: begin
            if (f7_zero)     sel_d.op_srl = 1'b1;
            else if (f7_alt) sel_d.op_sra = 1'b1;
            else             ill_d = 1'b1;
          end
        endcase
      end

      OPC_OP_IMM: begin
        a_d   = i_rs1_data;
        imm_d = imm_i;
        case (funct3)
          3'b000:  sel_d.op_add  = 1'b1;
          3'b010:  sel_d.op_slt  = 1'b1;
          3'b011:  sel_d.op_sltu = 1'b1;
          3'b100:  sel_d.op_xor  = 1'b1;
          3'b110:  sel_d.op_or   = 1'b1;
          3'b111:  sel_d.op_and  = 1'b1;
          3'b001: begin
            imm_d = imm_sh;
            if (f7_zero) sel_d.op_sll = 1'b1;
            else         ill_d = 1'b1;
          end
          default: begin
            imm_d = imm_sh;
            if (f7_zero)     sel_d.op_srl = 1'b1;
            else if (f7_alt) sel_d.op_sra = 1'b1;
            else             ill_d = 1'b1;
          end
        endcase
        b_d = imm_d;
      end

      OPC_BRANCH: begin
        a_d          = i_rs1_data;
        b_d          = i_rs2_data;
        imm_d        = imm_b;
        rd_d         = '0;
        cls_d.branch = 1'b1;
        case (funct3)
          3'b000:  sel_d.op_eq   = 1'b1;
          3'b001:  sel_d.op_neq  = 1'b1;
          3'b100:  sel_d.op_slt  = 1'b1;
          3'b101:  sel_d.op_ge   = 1'b1;
          3'b110:  sel_d.op_sltu = 1'b1;
          3'b111:  sel_d.op_geu  = 1'b1;
          default: ill_d = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        a_d          = i_rs1_data;
        imm_d        = imm_i;
        b_d          = imm_i;
        sel_d.op_add = 1'b1;
        cls_d.load   = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ill_d = 1'b1;
      end

      OPC_STORE: begin
        a_d          = i_rs1_data;
        imm_d        = imm_s;
        b_d          = imm_s;
        rd_d         = '0;
        sel_d.op_add = 1'b1;
        cls_d.store  = 1'b1;
        if (funct3 > 3'b010) ill_d = 1'b1;
      end

      OPC_LUI: begin
        imm_d        = imm_u;
        b_d          = imm_u;
        sel_d.op_add = 1'b1;
        cls_d.lui    = 1'b1;
      end

      OPC_AUIPC: begin
        a_d          = i_pc;
        imm_d        = imm_u;
        b_d          = imm_u;
        sel_d.op_add = 1'b1;
        cls_d.auipc  = 1'b1;
      end

      // Jumps only produce the link value here; the target adder lives elsewhere.
      OPC_JAL: begin
        a_d          = i_pc;
        b_d          = 32'd4;
        imm_d        = imm_j;
        sel_d.op_add = 1'b1;
        cls_d.jal    = 1'b1;
      end

      OPC_JALR: begin
        a_d          = i_pc;
        b_d          = 32'd4;
        imm_d        = imm_i;
        sel_d.op_add = 1'b1;
        cls_d.jalr   = 1'b1;
      end

      OPC_SYSTEM: begin
        imm_d        = imm_i;
        cls_d.system = 1'b1;
      end

      OPC_FENCE: begin
        imm_d       = imm_i;
        rd_d        = '0;
        cls_d.fence = 1'b1;
      end

      default: ill_d = 1'b1;
    endcase

    if (ill_d) begin
      sel_d = '0;
      cls_d = '0;
      a_d   = '0;
      b_d   = '0;
      imm_d = '0;
      rd_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_pc       <= RESET_PC;
      o_rd_addr  <= '0;
      o_imm      <= '0;
      o_rs2_data <= '0;
      o_funct3   <= '0;
      o_a        <= '0;
      o_b        <= '0;
      sel_q      <= '0;
      cls_q      <= '0;
      o_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      sel_q     <= '0;
      cls_q     <= '0;
      o_illegal <= 1'b0;
    end else if (!i_stall) begin
      o_valid    <= i_valid;
      o_pc       <= i_pc;
      o_rd_addr  <= rd_d;
      o_imm      <= imm_d;
      o_rs2_data <= i_rs2_data;
      o_funct3   <= funct3;
      o_a        <= a_d;
      o_b        <= b_d;
      // A bubble keeps the datapath fields but must not fire any control.
      sel_q      <= i_valid ? sel_d : '0;
      cls_q      <= i_valid ? cls_d : '0;
      o_illegal  <= i_valid & ill_d;
    end
  end

  assign o_alu      = o_valid;
  assign o_alu_add  = sel_q.op_add;
  assign o_alu_sub  = sel_q.op_sub;
  assign o_alu_slt  = sel_q.op_slt;
  assign o_alu_sltu = sel_q.op_sltu;
  assign o_alu_xor  = sel_q.op_xor;
  assign o_alu_or   = sel_q.op_or;
  assign o_alu_and  = sel_q.op_and;
  assign o_alu_sll  = sel_q.op_sll;
  assign o_alu_srl  = sel_q.op_srl;
  assign o_alu_sra  = sel_q.op_sra;
  assign o_alu_eq   = sel_q.op_eq;
  assign o_alu_neq  = sel_q.op_neq;
  assign o_alu_ge   = sel_q.op_ge;
  assign o_alu_geu  = sel_q.op_geu;

  assign o_load   = cls_q.load;
  assign o_store  = cls_q.store;
  assign o_branch = cls_q.branch;
  assign o_jal    = cls_q.jal;
  assign o_jalr   = cls_q.jalr;
  assign o_lui    = cls_q.lui;
  assign o_auipc  = cls_q.auipc;
  assign o_system = cls_q.system;
  assign o_fence  = cls_q.fence;

endmodule
